// File: rtl/music_pkg.sv
// Shared widths, constants, FSM state type and duration decode for the note sequencer.
package music_pkg;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DUR_W  = 4;
   localparam int unsigned TONE_W = 4;

   localparam logic [DUR_W+TONE_W-1:0] END_MARKER     = 8'h00;
   localparam int unsigned             DUR_ZERO_UNITS = 16;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_LATCH = 3'd2,
      ST_PLAY  = 3'd3,
      ST_DONE  = 3'd4
   } seq_state_t;

   // A zero duration field stands for the longest note.
   function automatic logic [DUR_W:0] dur_units(input logic [DUR_W-1:0] dur);
      return (dur == '0) ? (DUR_W+1)'(DUR_ZERO_UNITS) : {1'b0, dur};
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Duration-unit divider: tick pulses on every TICK_DIV-th enabled cycle; clr restarts the count.
module tick_prescaler #(
   parameter int unsigned TICK_DIV = 3125000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int unsigned   CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   assign tick = en && (cnt == LAST);

   always_ff @(posedge clk) begin
      if (!rst || clr)
         cnt <= '0;
      else if (en)
         cnt <= tick ? '0 : cnt + 1'b1;
   end

endmodule

// File: rtl/note_sequencer.sv
// Song ROM walker driving a tone generator; define NOTE_GAP_EN to silence the last
// GAP_CYCLES counted cycles of every note (articulation gap).
module note_sequencer
   import music_pkg::*;
#(
   parameter int unsigned TICK_DIV   = 3125000,
   parameter int unsigned GAP_CYCLES = 312500
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    play,
   input  logic                    loop_en,
   output logic [ADDR_W-1:0]       song_addr,
   input  logic [DUR_W+TONE_W-1:0] song_data,
   output logic [TONE_W-1:0]       tone,
   output logic                    note_start,
   output logic                    song_done
);

   if (TICK_DIV < 2 || GAP_CYCLES < 1 || GAP_CYCLES >= TICK_DIV) begin : g_param_check
      $error("note_sequencer: TICK_DIV/GAP_CYCLES out of range");
   end

   seq_state_t        state;
   logic [DUR_W:0]    units;
   logic [DUR_W:0]    unit_cnt;
   logic [TONE_W-1:0] note_tone;
   logic [TONE_W-1:0] tone_q;
   logic              counting;
   logic              tick;
   logic              last_unit;
   logic              gap;

   // Only PLAY cycles with play high advance the note; pausing freezes the divider.
   assign counting  = (state == ST_PLAY) && play;
   assign last_unit = (unit_cnt == units - 1'b1);
   assign song_done = (state == ST_DONE);

   tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .en   (counting),
      .clr  (state != ST_PLAY),
      .tick (tick)
   );

`ifdef NOTE_GAP_EN
   localparam int unsigned GW = $clog2(TICK_DIV + 1);
   logic [GW-1:0] tail_cnt;

   // The gap never spans more than one unit, so only the last unit needs a position count.
   always_ff @(posedge clk) begin
      if (!rst || state != ST_PLAY)
         tail_cnt <= '0;
      else if (counting && last_unit)
         tail_cnt <= tail_cnt + 1'b1;
   end

   assign gap = last_unit && (32'(tail_cnt) >= (TICK_DIV - GAP_CYCLES));
`else
   assign gap = 1'b0;
`endif

   always_comb begin
      tone = '0;
      case (state)
         ST_FETCH, ST_LATCH: tone = tone_q;
         ST_PLAY:            if (play && !gap) tone = note_tone;
         default:            tone = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= ST_IDLE;
         song_addr  <= '0;
         units      <= '0;
         unit_cnt   <= '0;
         note_tone  <= '0;
         tone_q     <= '0;
         note_start <= 1'b0;
      end else begin
         tone_q     <= tone;
         note_start <= 1'b0;
         case (state)
            ST_IDLE: begin
               song_addr <= '0;
               if (play) state <= ST_FETCH;
            end
            ST_FETCH: state <= ST_LATCH;
            ST_LATCH: begin
               if (song_data == END_MARKER) begin
                  if (loop_en) begin
                     song_addr <= '0;
                     state     <= ST_FETCH;
                  end else begin
                     state <= ST_DONE;
                  end
               end else begin
                  units      <= dur_units(song_data[TONE_W +: DUR_W]);
                  note_tone  <= song_data[TONE_W-1:0];
                  unit_cnt   <= '0;
                  note_start <= 1'b1;
                  state      <= ST_PLAY;
               end
            end
            ST_PLAY: begin
               if (tick) begin
                  if (last_unit) begin
                     unit_cnt  <= '0;
                     song_addr <= song_addr + 1'b1;
                     state     <= ST_FETCH;
                  end else begin
                     unit_cnt <= unit_cnt + 1'b1;
                  end
               end
            end
            ST_DONE: begin
               if (!play) begin
                  song_addr <= '0;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: a song-level model predicts notes and the end event.
`timescale 1ns/1ps
module tb_note_sequencer;

   localparam int TD  = 4;
   localparam int GAP = 1;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       play = 1'b0;
   logic       loop_en = 1'b0;
   logic [7:0] song_addr;
   logic [7:0] song_data;
   logic [3:0] tone;
   logic       note_start;
   logic       song_done;

   logic [7:0] rom [256];

   int total = 0;
   int bad   = 0;
   bit mon_en = 1'b0;

   typedef struct {
      bit is_done;
      int addr;
      int tn;
      int units;
      int period;
   } ev_t;

   ev_t sbq[$];

   note_sequencer #(.TICK_DIV(TD), .GAP_CYCLES(GAP)) dut (
      .clk        (clk),
      .rst        (rst),
      .play       (play),
      .loop_en    (loop_en),
      .song_addr  (song_addr),
      .song_data  (song_data),
      .tone       (tone),
      .note_start (note_start),
      .song_done  (song_done)
   );

   always #5 clk = ~clk;

   // Synchronous ROM: data follows the address one cycle later.
   always @(posedge clk) song_data <= rom[song_addr];

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish required finish before 1ms");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   // Song-level model: walk the ROM by the note rules, emitting expected events.
   function automatic void build_expect(input bit lp, input int max_ev);
      ev_t ev;
      int  a = 0;
      int  prev_units = 0;
      int  extra = 2;
      bit  first = 1'b1;
      int  n = 0;
      int  w;
      for (int guard = 0; guard < 2048 && n < max_ev; guard++) begin
         w = int'(rom[a]);
         if (w == 0) begin
            if (!lp) begin
               ev.is_done = 1'b1; ev.addr = a; ev.tn = 0; ev.units = 0; ev.period = 0;
               sbq.push_back(ev);
               n++;
               break;
            end
            a = 0;
            extra += 2;
         end else begin
            ev.is_done = 1'b0;
            ev.addr    = a;
            ev.tn      = w % 16;
            ev.units   = (w / 16 == 0) ? 16 : w / 16;
            ev.period  = first ? 0 : prev_units * TD + extra;
            sbq.push_back(ev);
            n++;
            prev_units = ev.units;
            extra      = 2;
            first      = 1'b0;
            a          = (a + 1) % 256;
         end
      end
   endfunction

   // Monitor: pops on note_start / song_done and checks tone, length and spacing.
   ev_t mon_e;
   int  cyc = 0;
   int  prev_ns_cyc = 0;
   bit  have_prev = 1'b0;
   bit  paused = 1'b0;
   bit  in_note = 1'b0;
   bit  done_q = 1'b0;
   int  cur_addr = 0;
   int  cur_tone = 0;
   int  cur_units = 0;
   int  counted = 0;
   int  exp_t;

   always @(negedge clk) begin
      cyc++;
      if (!mon_en) begin
         in_note   = 1'b0;
         have_prev = 1'b0;
         done_q    = 1'b0;
         paused    = 1'b0;
      end else begin
         if (!play) paused = 1'b1;
         if (in_note && int'(song_addr) != cur_addr) begin
            chk("note_len", counted, cur_units * TD);
            in_note = 1'b0;
         end
         if (note_start) begin
            if (sbq.size() == 0) begin
               chk("note_expected", sbq.size(), 1);
               cur_units = 0;
            end else begin
               mon_e = sbq.pop_front();
               chk("note_kind", int'(mon_e.is_done), 0);
               chk("note_addr", int'(song_addr), mon_e.addr);
               if (have_prev && !paused && mon_e.period != 0)
                  chk("note_period", cyc - prev_ns_cyc, mon_e.period);
               cur_addr  = mon_e.addr;
               cur_tone  = mon_e.tn;
               cur_units = mon_e.units;
            end
            in_note     = 1'b1;
            counted     = 0;
            have_prev   = 1'b1;
            prev_ns_cyc = cyc;
            paused      = !play;
         end
         if (in_note) begin
            if (play) begin
               exp_t = cur_tone;
`ifdef NOTE_GAP_EN
               if (counted >= cur_units * TD - GAP) exp_t = 0;
`endif
               chk("tone_play", int'(tone), exp_t);
               counted++;
            end else begin
               chk("tone_paused", int'(tone), 0);
            end
         end
         if (song_done && !done_q) begin
            if (sbq.size() == 0) begin
               chk("done_expected", sbq.size(), 1);
            end else begin
               mon_e = sbq.pop_front();
               chk("done_kind", int'(mon_e.is_done), 1);
               chk("done_addr", int'(song_addr), mon_e.addr);
            end
         end
         if (song_done) chk("done_tone", int'(tone), 0);
         done_q = song_done;
      end
   end

   task automatic tick_n(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom[i] = 8'h00;
   endtask

   task automatic reset_dut();
      mon_en = 1'b0;
      play   = 1'b0;
      rst    = 1'b0;
      tick_n(2);
      rst = 1'b1;
      tick_n(1);
   endtask

   task automatic wait_note(input int budget, input string name);
      int k = 0;
      while (!note_start && k < budget) begin
         tick_n(1);
         k++;
      end
      chk({name, "_note_seen"}, int'(note_start), 1);
   endtask

   task automatic wait_drain(input string name, input int budget, input bit rnd_play);
      int k = 0;
      while (sbq.size() != 0 && k < budget) begin
         if (rnd_play) play = ($urandom_range(0, 3) != 0);
         tick_n(1);
         k++;
      end
      if (sbq.size() != 0) begin
         chk({name, "_pending"}, sbq.size(), 0);
         sbq.delete();
      end
      mon_en = 1'b0;
      play   = 1'b0;
   endtask

   task automatic check_idle(input string name);
      tick_n(1);
      chk({name, "_idle_done"}, int'(song_done), 0);
      chk({name, "_idle_addr"}, int'(song_addr), 0);
      chk({name, "_idle_tone"}, int'(tone), 0);
   endtask

   task automatic run_song(input bit lp, input int max_ev, input bit rnd, input int budget,
                           input string name);
      reset_dut();
      loop_en = lp;
      build_expect(lp, max_ev);
      mon_en = 1'b1;
      play   = 1'b1;
      wait_drain(name, budget, rnd);
      if (!lp) check_idle(name);
   endtask

   int d;
   int t;
   int len;

   initial begin
      clear_rom();
      rst = 1'b0;
      tick_n(3);
      chk("rst_addr", int'(song_addr), 0);
      chk("rst_tone", int'(tone), 0);
      chk("rst_note_start", int'(note_start), 0);
      chk("rst_done", int'(song_done), 0);

      // Two notes then the end marker.
      rom[0] = 8'h23; rom[1] = 8'h15; rom[2] = 8'h00;
      run_song(1'b0, 10, 1'b0, 200, "basic");

      // Same song looping.
      run_song(1'b1, 5, 1'b0, 200, "loop");

      // Zero duration means 16 units.
      clear_rom();
      rom[0] = 8'h07;
      run_song(1'b0, 10, 1'b0, 200, "long");

      // Pause in the middle of a note.
      rom[0] = 8'h23;
      reset_dut();
      loop_en = 1'b0;
      build_expect(1'b0, 10);
      mon_en = 1'b1;
      play   = 1'b1;
      wait_note(20, "pause_mid");
      tick_n(3);
      play = 1'b0;
      tick_n(5);
      play = 1'b1;
      wait_drain("pause_mid", 200, 1'b0);
      check_idle("pause_mid");

      // Pause landing on the last counted cycle.
      reset_dut();
      build_expect(1'b0, 10);
      mon_en = 1'b1;
      play   = 1'b1;
      wait_note(20, "pause_last");
      tick_n(7);
      play = 1'b0;
      tick_n(2);
      play = 1'b1;
      wait_drain("pause_last", 200, 1'b0);
      check_idle("pause_last");

      // Random songs with random play pauses.
      for (int it = 0; it < 6; it++) begin
         clear_rom();
         len = $urandom_range(1, 5);
         for (int i = 0; i < len; i++) begin
            d = $urandom_range(0, 3);
            t = $urandom_range(0, 15);
            if (d == 0 && t == 0) t = 1;
            rom[i] = 8'(d * 16 + t);
         end
         run_song(1'b0, 20, 1'b1, 3000, "rand");
      end

      // Reset in the middle of the second note.
      clear_rom();
      rom[0] = 8'h23; rom[1] = 8'h15;
      reset_dut();
      play = 1'b1;
      wait_note(20, "rst_mid_a");
      tick_n(1);
      wait_note(40, "rst_mid_b");
      chk("rst_mid_pre_addr", int'(song_addr), 1);
      tick_n(2);
      rst = 1'b0;
      tick_n(1);
      chk("rst_mid_addr", int'(song_addr), 0);
      chk("rst_mid_tone", int'(tone), 0);
      chk("rst_mid_note_start", int'(note_start), 0);
      chk("rst_mid_done", int'(song_done), 0);
      rst  = 1'b1;
      play = 1'b0;
      tick_n(1);

      // 256 non-zero words: address wraps 255 -> 0.
      for (int i = 0; i < 256; i++) begin
         t = $urandom_range(0, 15);
         rom[i] = 8'(16 + t);
      end
      run_song(1'b0, 257, 1'b0, 2000, "wrap");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
